sw_input_cond: RTL and testbench

//  Conditions the raw board buttons/switches that drive the stopwatch core (SW).
//  - Synchronises each raw input, debounces it and edge-detects the buttons.
//  - Delivers clean RESET-request, PAUSE and ADJ/SEL levels to SW.
//  - Sits directly upstream of SW, in the same clk domain.

---
 rtl/sw_input_cond.sv | 113 +++++++++++
 tb/tb_sw_input_cond.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_input_cond.sv
// sw_input_cond: input conditioning for the stopwatch core.
// Each raw button or switch goes through a 2-flop synchroniser and then a
// debounce counter. The two buttons are also edge-detected to give press pulses.
// Build option: define PAUSE_TOGGLE_EN to make PAUSE a toggle flop driven by
// pause presses. Without it, PAUSE follows the debounced pause button level.

module sw_input_cond #(
    parameter int DB_CNT_MAX = 100000, // stable cycles needed before a level changes (>=2)
    parameter int CNT_W      = 17      // must satisfy 2**CNT_W > DB_CNT_MAX
) (
    input  logic clk,
    input  logic RESET,
    input  logic btn_rst_raw,
    input  logic btn_pause_raw,
    input  logic sw_adj_raw,
    input  logic sw_sel_raw,
    output logic rst_req,
    output logic pause_pulse,
    output logic PAUSE,
    output logic ADJ,
    output logic SEL
);

    // Channel layout in the packed per-channel vectors
    localparam int N_CH     = 4;
    localparam int CH_RST   = 0;
    localparam int CH_PAUSE = 1;
    localparam int CH_ADJ   = 2;
    localparam int CH_SEL   = 3;

    // Last count value before the debounced level is allowed to flip
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CNT_MAX - 1);

    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  s1_q;
    logic [N_CH-1:0]  s2_q;
    logic [N_CH-1:0]  stable_q;
    logic [N_CH-1:0]  stable_d;
    logic [N_CH-1:0]  stable_prev_q;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic             rst_req_q;
    logic             pause_pulse_q;

    assign raw = {sw_sel_raw, sw_adj_raw, btn_pause_raw, btn_rst_raw};

    // Debounce next-state: count while the synced input disagrees with the
    // debounced level, and flip the level on the terminal count
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
            cnt_d[i]    = '0;
            stable_d[i] = stable_q[i];
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_TERM) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of each debounced level; the pulse registers sample this
    assign rise = stable_q & ~stable_prev_q;

    // Synchroniser, debounce and edge-detect state
    always_ff @(posedge clk) begin
        if (RESET) begin
            s1_q          <= '0;
            s2_q          <= '0;
            cnt_q         <= '{default: '0};
            stable_q      <= '0;
            stable_prev_q <= '0;
            rst_req_q     <= 1'b0;
            pause_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values (s2 gets the old s1).
            s1_q          <= raw;
            s2_q          <= s1_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            rst_req_q     <= rise[CH_RST];
            pause_pulse_q <= rise[CH_PAUSE];
        end
    end

    assign rst_req     = rst_req_q;
    assign pause_pulse = pause_pulse_q;
    assign ADJ         = stable_q[CH_ADJ];
    assign SEL         = stable_q[CH_SEL];

`ifdef PAUSE_TOGGLE_EN
    logic pause_q;

    // Pause toggle: flips with each pause pulse and is visible in the same
    // cycle. A reset press wins over a coincident pause press.
    always_ff @(posedge clk) begin
        if (RESET || rise[CH_RST]) begin
            pause_q <= 1'b0;
        end else if (rise[CH_PAUSE]) begin
            pause_q <= ~pause_q;
        end
    end

    assign PAUSE = pause_q;
`else
    assign PAUSE = stable_q[CH_PAUSE];
`endif

endmodule

// File: tb/tb_sw_input_cond.sv
// Testbench for sw_input_cond (DB_CNT_MAX=4, CNT_W=3, 10 ns clock).
// A reference model turns each sampled input cycle into an expected output
// vector and pushes it onto a queue. A monitor pops that queue after each edge
// and compares it with the DUT outputs. Directed timing checks sit on top.

module tb_sw_input_cond;

    localparam int DB = 4;

    logic clk;
    logic RESET;
    logic btn_rst_raw, btn_pause_raw, sw_adj_raw, sw_sel_raw;
    logic rst_req, pause_pulse, PAUSE, ADJ, SEL;

    int n_checks = 0;
    int n_pass   = 0;
    int rst_cnt  = 0;
    int pause_cnt = 0;

    // Expected {rst_req, pause_pulse, PAUSE, ADJ, SEL} after each edge
    logic [4:0] exp_q [$];

    sw_input_cond #(.DB_CNT_MAX(DB), .CNT_W(3)) dut (
        .clk          (clk),
        .RESET        (RESET),
        .btn_rst_raw  (btn_rst_raw),
        .btn_pause_raw(btn_pause_raw),
        .sw_adj_raw   (sw_adj_raw),
        .sw_sel_raw   (sw_sel_raw),
        .rst_req      (rst_req),
        .pause_pulse  (pause_pulse),
        .PAUSE        (PAUSE),
        .ADJ          (ADJ),
        .SEL          (SEL)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Each input is seen two samples late. The debounced level flips once the
    // last DB synced samples since reset all disagree with it. A pulse comes
    // one cycle after the level rises.
    bit m_s1 [4];
    bit m_s2 [4];
    bit m_level [4];
    bit m_prev [4];
    bit m_hist [4][$];
    bit m_raw [4];
    bit m_old [4];
    bit m_rise [4];
    bit m_pulse_rst, m_pulse_pause, m_pause;

    always @(posedge clk) begin
        m_raw = '{btn_rst_raw, btn_pause_raw, sw_adj_raw, sw_sel_raw};
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_prev[i] = 0;
                m_hist[i].delete();
            end
            m_pulse_rst = 0; m_pulse_pause = 0; m_pause = 0;
        end else begin
            m_old = m_level;
            for (int i = 0; i < 4; i++) begin
                bit synced;
                bit all_diff;
                synced  = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = m_raw[i];
                m_hist[i].push_back(synced);
                if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
                all_diff = (m_hist[i].size() == DB);
                foreach (m_hist[i][k]) if (m_hist[i][k] == m_level[i]) all_diff = 0;
                if (all_diff) m_level[i] = !m_level[i];
                m_rise[i] = m_old[i] && !m_prev[i];
                m_prev[i] = m_old[i];
            end
            m_pulse_rst   = m_rise[0];
            m_pulse_pause = m_rise[1];
`ifdef PAUSE_TOGGLE_EN
            if (m_pulse_rst) m_pause = 0;
            else if (m_pulse_pause) m_pause = !m_pause;
`else
            m_pause = m_level[1];
`endif
        end
        exp_q.push_back({m_pulse_rst, m_pulse_pause, m_pause, m_level[2], m_level[3]});
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (rst_req) rst_cnt++;
        if (pause_pulse) pause_cnt++;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            check("outputs", {rst_req, pause_pulse, PAUSE, ADJ, SEL}, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit br, input bit bp, input bit sa,
                         input bit ss, input int n);
        repeat (n) begin
            @(negedge clk);
            RESET = r; btn_rst_raw = br; btn_pause_raw = bp;
            sw_adj_raw = sa; sw_sel_raw = ss;
        end
    endtask

    // Leaves time just after edge (n-1) when counted from the next posedge
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int r0;
        RESET = 1; btn_rst_raw = 1; btn_pause_raw = 1; sw_adj_raw = 1; sw_sel_raw = 1;

        // 1: reset with all inputs held high, then release
        drive(1, 1, 1, 1, 1, 10);
        check("in_reset", {rst_req, pause_pulse, PAUSE, ADJ, SEL}, 5'b00000);
        drive(0, 1, 1, 1, 1, 1);
        wait_edges(6);
        check("rel_e5_pulses", {3'b000, rst_req, pause_pulse}, 5'b00000);
        check("rel_e5_levels", {3'b000, ADJ, SEL}, 5'b00011);
        wait_edges(1);
        check("rel_e6_pulses", {3'b000, rst_req, pause_pulse}, 5'b00011);
        wait_edges(1);
        check("rel_e7_pulses", {3'b000, rst_req, pause_pulse}, 5'b00000);
        drive(0, 0, 0, 0, 0, 12);

        // 2: pause press with exact pulse timing, then a second press
        drive(0, 0, 1, 0, 0, 1);
        wait_edges(6);
        check("pause_e5", {4'b0000, pause_pulse}, 5'b00000);
        wait_edges(1);
        check("pause_e6", {3'b000, pause_pulse, PAUSE}, 5'b00011);
        wait_edges(1);
        check("pause_e7", {4'b0000, pause_pulse}, 5'b00000);
        drive(0, 0, 1, 0, 0, 12);
        drive(0, 0, 0, 0, 0, 12);
        drive(0, 0, 1, 0, 0, 20);
        drive(0, 0, 0, 0, 0, 12);
        check("pause_second", {4'b0000, PAUSE}, 5'b00000);

        // 3: short glitch must not produce a pulse
        p0 = pause_cnt;
        drive(0, 0, 1, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 12);
        check("glitch_pulses", 5'(pause_cnt - p0), 5'd0);
        check("glitch_pause", {4'b0000, PAUSE}, 5'b00000);

        // 4: ADJ and SEL together, set and release
        drive(0, 0, 0, 1, 1, 1);
        wait_edges(5);
        check("adjsel_e4", {3'b000, ADJ, SEL}, 5'b00000);
        wait_edges(1);
        check("adjsel_e5", {3'b000, ADJ, SEL}, 5'b00011);
        drive(0, 0, 0, 1, 1, 10);
        drive(0, 0, 0, 0, 0, 1);
        wait_edges(5);
        check("adjsel_rel_e4", {3'b000, ADJ, SEL}, 5'b00011);
        wait_edges(1);
        check("adjsel_rel_e5", {3'b000, ADJ, SEL}, 5'b00000);
        drive(0, 0, 0, 0, 0, 10);

        // 5: set PAUSE, then press reset and pause together
        drive(0, 0, 1, 0, 0, 12);
        drive(0, 0, 0, 0, 0, 12);
        drive(0, 1, 1, 0, 0, 1);
        wait_edges(7);
        check("both_e6", {3'b000, rst_req, pause_pulse}, 5'b00011);
        drive(0, 1, 1, 0, 0, 10);
        drive(0, 0, 0, 0, 0, 12);
        check("both_pause_end", {4'b0000, PAUSE}, 5'b00000);

        // 6: RESET two cycles into a held reset-button press
        drive(0, 1, 0, 0, 0, 2);
        drive(1, 1, 0, 0, 0, 3);
        check("mid_reset", {rst_req, pause_pulse, PAUSE, ADJ, SEL}, 5'b00000);
        r0 = rst_cnt;
        drive(0, 1, 0, 0, 0, 1);
        wait_edges(6);
        check("rerun_e5", {4'b0000, rst_req}, 5'b00000);
        wait_edges(1);
        check("rerun_e6", {4'b0000, rst_req}, 5'b00001);
        drive(0, 1, 0, 0, 0, 10);
        check("rerun_once", 5'(rst_cnt - r0), 5'd1);
        drive(0, 0, 0, 0, 0, 12);

        // Random segments: each input toggles at random, with occasional RESET
        begin
            bit v [4];
            v = '{0, 0, 0, 0};
            for (int s = 0; s < 400; s++) begin
                for (int i = 0; i < 4; i++) if ($urandom_range(1, 0) == 1) v[i] = !v[i];
                drive(($urandom_range(39, 0) == 0), v[0], v[1], v[2], v[3],
                      int'($urandom_range(8, 1)));
            end
        end
        drive(0, 0, 0, 0, 0, 12);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
